// File: rtl/corevx_tlb_assoc.sv
// ============================================================================
// corevx_tlb_assoc : set-associative TLB with registered resolve, dedup write,
//                    per-set round-robin replacement and invalidate-all sweep
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module corevx_tlb_assoc #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 1,
  parameter int VPN_W     = 20,
  parameter int PPN_W     = 22,
  parameter int ATAG_W    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          command,
  output logic                                cmd_ready,
  input  logic [VPN_W-1:0]                    virtual_address,
  input  logic [VPN_W-1:0]                    virtual_address_w,
  input  logic [ATAG_W-1:0]                   accesstag_w,
  input  logic [PPN_W-1:0]                    phys_w,
  output logic                                resolve_done,
  output logic                                hit,
  output logic [((WAYS_W > 0) ? WAYS_W : 1)-1:0] hit_way,
  output logic [ATAG_W-1:0]                   accesstag_r,
  output logic [PPN_W-1:0]                    phys_r
);

  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int WAYS    = 1 << WAYS_W;
  localparam int TAG_W   = VPN_W - ENTRIES_W;
  localparam int HW_W    = (WAYS_W > 0) ? WAYS_W : 1;

  localparam logic [1:0] CMD_RESOLVE = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_INVAL   = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_INVAL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ENTRIES_W-1:0]   sweep_q, sweep_d;
  logic [WAYS-1:0]        valid_q [ENTRIES];
  logic [WAYS-1:0]        valid_d [ENTRIES];
  logic [HW_W-1:0]        rr_q    [ENTRIES];
  logic [HW_W-1:0]        rr_d    [ENTRIES];

  logic                   resolve_done_q, resolve_done_d;
  logic                   hit_q, hit_d;
  logic [HW_W-1:0]        hit_way_q, hit_way_d;
  logic [ATAG_W-1:0]      accesstag_q, accesstag_d;
  logic [PPN_W-1:0]       phys_q, phys_d;

  // Payload arrays carry no reset; only the valid bits gate their use.
  logic [ATAG_W-1:1]      attrs_mem [WAYS][ENTRIES];
  logic [TAG_W-1:0]       vtag_mem  [WAYS][ENTRIES];
  logic [PPN_W-1:0]       ppn_mem   [WAYS][ENTRIES];

  logic [ENTRIES_W-1:0]   r_set, w_set;
  logic [TAG_W-1:0]       r_tag, w_tag;
  logic                   lk_hit;
  logic [HW_W-1:0]        lk_way;
  logic                   wm_found, wi_found, use_rr, mem_we;
  logic [HW_W-1:0]        wm_way, wi_way, victim, rr_next;

  assign r_set = virtual_address[ENTRIES_W-1:0];
  assign r_tag = virtual_address[VPN_W-1:ENTRIES_W];
  assign w_set = virtual_address_w[ENTRIES_W-1:0];
  assign w_tag = virtual_address_w[VPN_W-1:ENTRIES_W];

  assign cmd_ready    = (state_q == S_IDLE);
  assign resolve_done = resolve_done_q;
  assign hit          = hit_q;
  assign hit_way      = hit_way_q;
  assign accesstag_r  = accesstag_q;
  assign phys_r       = phys_q;

  // Descending scans so the lowest-index candidate wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[r_set][w] && (vtag_mem[w][r_set] == r_tag)) begin
        lk_hit = 1'b1;
        lk_way = HW_W'(w);
      end
    end
  end

  always_comb begin
    wm_found = 1'b0;
    wm_way   = '0;
    wi_found = 1'b0;
    wi_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w_set][w] && (vtag_mem[w][w_set] == w_tag)) begin
        wm_found = 1'b1;
        wm_way   = HW_W'(w);
      end
      if (!valid_q[w_set][w]) begin
        wi_found = 1'b1;
        wi_way   = HW_W'(w);
      end
    end
    use_rr  = !wm_found && !wi_found;
    victim  = wm_found ? wm_way : (wi_found ? wi_way : rr_q[w_set]);
    rr_next = (rr_q[w_set] == HW_W'(WAYS - 1)) ? '0 : rr_q[w_set] + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    valid_d        = valid_q;
    rr_d           = rr_q;
    resolve_done_d = 1'b0;
    hit_d          = hit_q;
    hit_way_d      = hit_way_q;
    accesstag_d    = accesstag_q;
    phys_d         = phys_q;
    mem_we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (command)
          CMD_RESOLVE: begin
            resolve_done_d = 1'b1;
            hit_d          = lk_hit;
            hit_way_d      = lk_hit ? lk_way : '0;
            accesstag_d    = lk_hit ? {attrs_mem[lk_way][r_set], 1'b1} : '0;
            phys_d         = lk_hit ? ppn_mem[lk_way][r_set] : '0;
          end
          CMD_WRITE: begin
            mem_we                  = 1'b1;
            valid_d[w_set][victim]  = accesstag_w[0];
            if (use_rr) begin
              rr_d[w_set] = rr_next;
            end
          end
          CMD_INVAL: begin
            state_d = S_INVAL;
            sweep_d = '0;
          end
          default: ;
        endcase
      end
      S_INVAL: begin
        valid_d[sweep_q] = '0;
        rr_d[sweep_q]    = '0;
        sweep_d          = sweep_q + 1'b1;
        if (sweep_q == ENTRIES_W'(ENTRIES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sweep_q        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= '0;
        rr_q[i]    <= '0;
      end
      resolve_done_q <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      accesstag_q    <= '0;
      phys_q         <= '0;
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      valid_q        <= valid_d;
      rr_q           <= rr_d;
      resolve_done_q <= resolve_done_d;
      hit_q          <= hit_d;
      hit_way_q      <= hit_way_d;
      accesstag_q    <= accesstag_d;
      phys_q         <= phys_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      attrs_mem[victim][w_set] <= accesstag_w[ATAG_W-1:1];
      vtag_mem[victim][w_set]  <= w_tag;
      ppn_mem[victim][w_set]   <= phys_w;
    end
  end

endmodule

`default_nettype wire
